// File: rtl/bitstream_unpacker_pkg.sv
// Shared word format for the serial frame link: LSB-first bit order, addr in the high nibble.
package bitstream_unpacker_pkg;

    localparam int unsigned FRAME_WORDS = 16;
    localparam int unsigned WORD_W      = 8;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned DATA_W      = 4;

    // Stream bit 8*w+b carries bit b of word w; bits [7:4] are addr, [3:0] are data.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } word_t;

    function automatic word_t pack_word(input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] data);
        word_t w;
        w.addr = addr;
        w.data = data;
        return w;
    endfunction

endpackage

// File: rtl/frame_bank.sv
// Two-bank frame storage: one write port and one registered read port.
module frame_bank
    import bitstream_unpacker_pkg::*;
#(
    parameter int unsigned NWORDS = FRAME_WORDS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic                      wsel,
    input  logic [$clog2(NWORDS)-1:0] widx,
    input  word_t                     wword,
    input  logic                      re,
    input  logic                      rsel,
    input  logic [$clog2(NWORDS)-1:0] ridx,
    output word_t                     rword
);

    word_t mem [2][NWORDS];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wsel][widx] <= wword;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rword <= '0;
        end else if (re) begin
            rword <= mem[rsel][ridx];
        end
    end

endmodule

// File: rtl/bitstream_unpacker.sv
// Serial-to-parallel frame receiver: fills one bank from the 1-bit stream while replaying the other.
module bitstream_unpacker
    import bitstream_unpacker_pkg::*;
#(
    parameter int unsigned NWORDS = FRAME_WORDS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena_in,
    input  logic       data_in,
    output logic       ena_out,
    output logic [3:0] addr_out,
    output logic [3:0] data_out,
    output logic [3:0] idx_out,
    output logic       sof_out
);

    localparam int unsigned IDX_W      = $clog2(NWORDS);
    localparam int unsigned BCNT_W     = IDX_W + 3;
    localparam int unsigned FRAME_BITS = NWORDS * WORD_W;

    typedef enum logic {IDLE, PLAY} state_t;

    logic [BCNT_W-1:0] bcnt;
    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] asm_c;
    logic              wsel;
    logic              word_done_c;
    logic              frame_done_c;

    state_t            state, state_n;
    logic [IDX_W-1:0]  rcnt, rcnt_n;
    logic              rsel, rsel_n;
    logic              re_c;
    logic              ena_n, sof_n;
    logic [3:0]        idx_n;
    word_t             rword;

    // Current bit merged into the partial word at its final position.
    always_comb begin
        asm_c              = sreg;
        asm_c[bcnt[2:0]]   = data_in;
    end

    assign word_done_c  = ena_in && (bcnt[2:0] == 3'd7);
    assign frame_done_c = ena_in && (bcnt == BCNT_W'(FRAME_BITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt <= '0;
            sreg <= '0;
            wsel <= 1'b0;
        end else if (ena_in) begin
            sreg <= asm_c;
            bcnt <= bcnt + BCNT_W'(1);
            if (frame_done_c) begin
                wsel <= ~wsel;
            end
        end
    end

    frame_bank #(.NWORDS(NWORDS)) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (word_done_c),
        .wsel  (wsel),
        .widx  (bcnt[BCNT_W-1:3]),
        .wword (word_t'(asm_c)),
        .re    (re_c),
        .rsel  (rsel),
        .ridx  (rcnt),
        .rword (rword)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rcnt    <= '0;
            rsel    <= 1'b0;
            ena_out <= 1'b0;
            sof_out <= 1'b0;
            idx_out <= '0;
        end else begin
            state   <= state_n;
            rcnt    <= rcnt_n;
            rsel    <= rsel_n;
            ena_out <= ena_n;
            sof_out <= sof_n;
            idx_out <= idx_n;
        end
    end

    // Replay starts on the edge that completes a frame, so word 0 lands one edge later.
    always_comb begin
        state_n = state;
        rcnt_n  = rcnt;
        rsel_n  = rsel;
        re_c    = 1'b0;
        ena_n   = 1'b0;
        sof_n   = 1'b0;
        idx_n   = idx_out;
        case (state)
            IDLE: begin
                if (frame_done_c) begin
                    state_n = PLAY;
                    rsel_n  = wsel;
                    rcnt_n  = '0;
                end
            end
            PLAY: begin
                re_c   = 1'b1;
                ena_n  = 1'b1;
                sof_n  = (rcnt == '0);
                idx_n  = 4'(rcnt);
                rcnt_n = rcnt + IDX_W'(1);
                if (rcnt == IDX_W'(NWORDS - 1)) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign addr_out = rword.addr;
    assign data_out = rword.data;

endmodule
